board_frame_buffer: RTL and testbench
=====================================

Name: board_frame_buffer

Overview:
- Receiving end of the pixel-plot interface (x, y, colour, plot) driven by the board drawing datapath.
- Stores a 160x120, 3-bit-colour frame and scans it out continuously as 640x480@60 VGA, each stored pixel shown as a 4x4 block.
- Sits between the draw datapath and the DE-series VGA DAC pins.
- Includes a hardware clear engine so the game FSM can blank the screen without 19200 plot cycles of its own.

Parameters:
- H_RES, 160, stored frame width in pixels.
- V_RES, 120, stored frame height in pixels.
- BG_COLOUR, 3'b000, colour written by the clear engine.

Ports:
- clk  in  1  25 MHz pixel clock; the only clock.
- reset  in  1  asynchronous, active-high.
- x  in  8  write column.
- y  in  7  write row.
- colour  in  3  write colour {R,G,B}.
- plot  in  1  write strobe, one pixel per cycle.
- clear  in  1  pulse; starts a full-frame clear.
- clear_busy  out  1  high while the clear engine owns the write port.
- vga_r  out  8  red; 8'hFF if colour[2] else 8'h00.
- vga_g  out  8  green; from colour[1].
- vga_b  out  8  blue; from colour[0].
- vga_hs  out  1  horizontal sync, active-low.
- vga_vs  out  1  vertical sync, active-low.
- vga_blank_n  out  1  high during the visible region.
- frame_start  out  1  one-cycle pulse when the first visible pixel (0,0) appears on the outputs.

Behaviour:
- Reset (async, all outputs):
  - hcount, vcount, clear FSM and pipeline registers go to 0/IDLE.
  - vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, frame_start=0, clear_busy=0.
  - Memory contents are not reset.
- Memory: 19200 x 3 bits, address = y*160 + x. One synchronous write port and one synchronous read port. Read of an address written in the same cycle returns the old data.
- Write acceptance: a write occurs on a clk edge when plot=1, x<H_RES, y<V_RES, and the clear FSM is IDLE. Out-of-range or blocked plots are silently dropped; there is no queueing.
- Timing counters:
  - hcount runs 0..799; vcount runs 0..524 and increments when hcount wraps.
  - Horizontal: visible 0..639; hsync active for hcount 656..751.
  - Vertical: visible 0..479; vsync active for vcount 490..491.
- Read address = (vcount>>2)*160 + (hcount>>2), computed from the current counters.
- Pipeline, 2 cycles total:
  - Stage 1: memory read; sync and visible flags registered.
  - Stage 2: colour expanded to 8-bit channels and registered with vga_hs, vga_vs and vga_blank_n.
  - Outputs for counter position (h,v) appear 2 cycles after the counters hold (h,v).
  - When vga_blank_n=0, vga_r/g/b are forced to 0.
- frame_start: asserted on the same cycle that vga_blank_n first rises for position (0,0).
- Clear FSM:
  - IDLE: clear=1 -> CLEAR, caddr=0, clear_busy=1 on the next cycle.
  - CLEAR: writes BG_COLOUR at caddr each cycle and increments caddr. After the write of address 19199 -> IDLE, clear_busy=0 on the following cycle. A clear takes 19200 cycles.
  - clear=1 while in CLEAR is ignored (no restart).
  - plot during CLEAR is dropped.
- Scan-out never stalls, including during a clear; a partially cleared frame may be displayed.
- Reset mid-clear: FSM returns to IDLE immediately; the memory is left partially cleared.

Test Plan:
- Plot (x=0,y=0,colour=3'b101), then run to the frame start -> for hcount 0..3 on vcount 0..3 (output-aligned), vga_r=8'hFF, vga_g=8'h00, vga_b=8'hFF, and frame_start pulses exactly once per 420000 cycles.
- Plot (159,119,3'b010) and plot (160,5,3'b111) -> the last 4x4 block shows green only; the x=160 write leaves addresses 5*160+0 and 6*160+0 unchanged.
- Free-run one frame -> vga_hs low for exactly 96 cycles, asserting at output-aligned hcount 656. vga_vs low for exactly 1600 cycles (2 lines). vga_blank_n high for 640x480 positions, and vga_r/g/b=0 whenever vga_blank_n=0.
- Fill the frame with 3'b111, pulse clear with BG_COLOUR=3'b000 -> clear_busy high for exactly 19200 cycles. A plot (10,10,3'b100) issued mid-clear is dropped. The next frame is all black.
- Start a clear, assert reset after 5000 cycles -> clear_busy=0 and syncs deasserted immediately; after release, addresses 0..4999 read 000 and address 5000+ retain 111.
- Plot to address A on the same cycle the scan reads A -> the current output shows the old colour; the next frame shows the new colour.

Source files
------------

// File: rtl/board_frame_buffer_if.sv
// -----------------------------------------------------------------------------
// board_frame_buffer_if
// Pixel-plot bus between the board drawing datapath (master) and the frame
// buffer (slave).
//   x          [7:0] write column
//   y          [6:0] write row
//   colour     [2:0] write colour {R,G,B}
//   plot             write strobe, one pixel per cycle
//   clear            pulse that starts a full-frame clear
//   clear_busy       high while the clear engine owns the write port
// -----------------------------------------------------------------------------
interface board_frame_buffer_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       clear;
  logic       clear_busy;

  modport master (
    output x, y, colour, plot, clear,
    input  clear_busy
  );

  modport slave (
    input  x, y, colour, plot, clear,
    output clear_busy
  );
endinterface

// File: rtl/board_frame_buffer.sv
// -----------------------------------------------------------------------------
// board_frame_buffer
// Stores an H_RES x V_RES frame of 3-bit pixels and scans it out continuously
// as VGA, each stored pixel shown as a 4x4 block. A clear engine can overwrite
// the whole frame with BG_COLOUR, one address per cycle.
// Ports:
//   clk          pixel clock (25 MHz for 640x480@60)
//   reset        asynchronous, active-high
//   plot_if      plot bus (x, y, colour, plot, clear in; clear_busy out)
//   vga_r/g/b    8-bit colour channels, all-ones or all-zeros per colour bit
//   vga_hs/vs    active-low syncs
//   vga_blank_n  high during the visible region
//   frame_start  one-cycle pulse with the first visible pixel (0,0)
// The porch/sync widths are parameters so a reduced raster can be built; the
// defaults give the standard 800x525 total raster.
// -----------------------------------------------------------------------------
module board_frame_buffer #(
  parameter int         H_RES     = 160,
  parameter int         V_RES     = 120,
  parameter logic [2:0] BG_COLOUR = 3'b000,
  parameter int         H_FRONT   = 16,
  parameter int         H_SYNC    = 96,
  parameter int         H_BACK    = 48,
  parameter int         V_FRONT   = 10,
  parameter int         V_SYNC    = 2,
  parameter int         V_BACK    = 33
) (
  input  logic                        clk,
  input  logic                        reset,
  board_frame_buffer_if.slave         plot_if,
  output logic [7:0]                  vga_r,
  output logic [7:0]                  vga_g,
  output logic [7:0]                  vga_b,
  output logic                        vga_hs,
  output logic                        vga_vs,
  output logic                        vga_blank_n,
  output logic                        frame_start
);

  localparam int H_VIS   = H_RES * 4;
  localparam int V_VIS   = V_RES * 4;
  localparam int H_TOTAL = H_VIS + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VIS + V_FRONT + V_SYNC + V_BACK;
  localparam int DEPTH   = H_RES * V_RES;
  localparam int AW      = $clog2(DEPTH);
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [HCW-1:0] hcount_q, hcount_d;
  logic [VCW-1:0] vcount_q, vcount_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  always_comb begin
    hcount_d = hcount_q + HCW'(1);
    vcount_d = vcount_q;
    if (hcount_q == HCW'(H_TOTAL - 1)) begin
      hcount_d = '0;
      vcount_d = (vcount_q == VCW'(V_TOTAL - 1)) ? '0 : vcount_q + VCW'(1);
    end
  end

  logic visible;
  logic hs_active;
  logic vs_active;
  logic first_pixel;

  assign visible     = (hcount_q < HCW'(H_VIS)) && (vcount_q < VCW'(V_VIS));
  assign hs_active   = (hcount_q >= HCW'(H_VIS + H_FRONT)) &&
                       (hcount_q <  HCW'(H_VIS + H_FRONT + H_SYNC));
  assign vs_active   = (vcount_q >= VCW'(V_VIS + V_FRONT)) &&
                       (vcount_q <  VCW'(V_VIS + V_FRONT + V_SYNC));
  assign first_pixel = (hcount_q == '0) && (vcount_q == '0);

  // Outside the visible window the scan address would run past the end of
  // the frame; park it at 0 since the data is blanked there anyway.
  logic [AW-1:0] rd_addr;
  always_comb begin
    rd_addr = '0;
    if (visible) begin
      rd_addr = AW'((32'(vcount_q) >> 2) * H_RES + (32'(hcount_q) >> 2));
    end
  end

  // ---------------------------------------------------------------------------
  // Write port arbitration and clear engine
  // ---------------------------------------------------------------------------
  typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_t;

  clr_state_t    state_q, state_d;
  logic [AW-1:0] caddr_q, caddr_d;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [2:0]    mem_wdata;
  logic          plot_ok;
  logic [AW-1:0] plot_addr;

  assign plot_ok   = plot_if.plot &&
                     (32'(plot_if.x) < H_RES) && (32'(plot_if.y) < V_RES);
  assign plot_addr = AW'(32'(plot_if.y) * H_RES + 32'(plot_if.x));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      caddr_q <= '0;
    end else begin
      state_q <= state_d;
      caddr_q <= caddr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    caddr_d   = caddr_q;
    mem_we    = 1'b0;
    mem_waddr = plot_addr;
    mem_wdata = plot_if.colour;
    case (state_q)
      ST_IDLE: begin
        mem_we = plot_ok;
        if (plot_if.clear) begin
          state_d = ST_CLEAR;
          caddr_d = '0;
        end
      end
      ST_CLEAR: begin
        // The clear engine owns the write port; plots and further clear
        // pulses are ignored until the last address has been written.
        mem_we    = 1'b1;
        mem_waddr = caddr_q;
        mem_wdata = BG_COLOUR;
        caddr_d   = caddr_q + AW'(1);
        if (caddr_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          caddr_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign plot_if.clear_busy = (state_q == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Frame memory: one write port, one registered read port. Non-blocking
  // update means a same-cycle read of a written address returns old data.
  // ---------------------------------------------------------------------------
  logic [2:0] mem [DEPTH];
  logic [2:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    rd_data_q <= mem[rd_addr];
  end

  // ---------------------------------------------------------------------------
  // Scan pipeline: stage 1 aligns flags with the memory read, stage 2 drives
  // the pins. Syncs are kept in their active-low form throughout.
  // ---------------------------------------------------------------------------
  logic       vis1_q, hs1_q, vs1_q, first1_q;
  logic [7:0] vga_r_q, vga_g_q, vga_b_q;
  logic       vga_hs_q, vga_vs_q, vga_blank_n_q, frame_start_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vis1_q        <= 1'b0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      first1_q      <= 1'b0;
      vga_r_q       <= 8'h00;
      vga_g_q       <= 8'h00;
      vga_b_q       <= 8'h00;
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
      vga_blank_n_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      vis1_q        <= visible;
      hs1_q         <= ~hs_active;
      vs1_q         <= ~vs_active;
      first1_q      <= first_pixel;
      vga_r_q       <= {8{vis1_q & rd_data_q[2]}};
      vga_g_q       <= {8{vis1_q & rd_data_q[1]}};
      vga_b_q       <= {8{vis1_q & rd_data_q[0]}};
      vga_hs_q      <= hs1_q;
      vga_vs_q      <= vs1_q;
      vga_blank_n_q <= vis1_q;
      frame_start_q <= first1_q;
    end
  end

  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign vga_blank_n = vga_blank_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_board_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_board_frame_buffer
// Runs the frame buffer on a reduced raster (8x6 stored pixels, 32x24 visible,
// standard 96-cycle hsync and 2-line vsync) so several frames fit in a short
// run. A behavioural model predicts every output on every cycle; literal
// checks pin the model against hand-computed values.
// -----------------------------------------------------------------------------
module tb_board_frame_buffer;
  localparam int         H_RES   = 8;
  localparam int         V_RES   = 6;
  localparam logic [2:0] BG      = 3'b000;
  localparam int         H_FRONT = 16;
  localparam int         H_SYNC  = 96;
  localparam int         H_BACK  = 8;
  localparam int         V_FRONT = 10;
  localparam int         V_SYNC  = 2;
  localparam int         V_BACK  = 3;
  localparam int         HV      = H_RES * 4;                        // 32
  localparam int         VV      = V_RES * 4;                        // 24
  localparam int         HT      = HV + H_FRONT + H_SYNC + H_BACK;   // 152
  localparam int         VT      = VV + V_FRONT + V_SYNC + V_BACK;   // 39
  localparam int         FRAME   = HT * VT;                          // 5928
  localparam int         N       = H_RES * V_RES;                    // 48

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #20 clk = ~clk;

  board_frame_buffer_if bus ();
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, frame_start;

  board_frame_buffer #(
    .H_RES(H_RES), .V_RES(V_RES), .BG_COLOUR(BG),
    .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) dut (
    .clk(clk), .reset(rst), .plot_if(bus),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .frame_start(frame_start)
  );

  int errors = 0;
  int checks = 0;
  int fail_prints = 0;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
    logic [2:0]  col;
    logic        known;
  } exp_t;

  logic [2:0] mem_m   [N];
  bit         known_m [N];
  int         pos_m = 0;        // raster position held by the counters now
  int         clr_left_m = 0;   // clear writes still to be done
  exp_t       st1_m, out_m;     // expectation 1 and 2 cycles behind the counters

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    e.h = 16'hFFFF; e.v = 16'hFFFF;
    e.hs = 1'b1; e.vs = 1'b1; e.known = 1'b1;
    return e;
  endfunction

  function automatic exp_t expect_at(int p);
    exp_t e;
    int h, v, a;
    h = p % HT;
    v = p / HT;
    e.h = 16'(h);
    e.v = 16'(v);
    e.blank = (h < HV) && (v < VV);
    e.hs = !((h >= HV + H_FRONT) && (h < HV + H_FRONT + H_SYNC));
    e.vs = !((v >= VV + V_FRONT) && (v < VV + V_FRONT + V_SYNC));
    e.fs = (p == 0);
    e.col = 3'b000;
    e.known = 1'b1;
    if (e.blank) begin
      a = (v / 4) * H_RES + (h / 4);
      e.col = mem_m[a];
      e.known = known_m[a];
    end
    return e;
  endfunction

  initial begin
    st1_m = idle_exp();
    out_m = idle_exp();
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_m      <= 0;
      clr_left_m <= 0;
      st1_m      <= idle_exp();
      out_m      <= idle_exp();
    end else begin
      st1_m <= expect_at(pos_m);   // reads memory before this edge's write
      out_m <= st1_m;
      pos_m <= (pos_m + 1) % FRAME;
      if (clr_left_m > 0) begin
        mem_m[N - clr_left_m]   <= BG;
        known_m[N - clr_left_m] <= 1'b1;
        clr_left_m              <= clr_left_m - 1;
      end else begin
        if (bus.clear) clr_left_m <= N;
        if (bus.plot && int'(bus.x) < H_RES && int'(bus.y) < V_RES) begin
          mem_m[int'(bus.y) * H_RES + int'(bus.x)]   <= bus.colour;
          known_m[int'(bus.y) * H_RES + int'(bus.x)] <= 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [7:0] er, eg, eb;
    logic       ok;
    er = (out_m.blank && out_m.col[2]) ? 8'hFF : 8'h00;
    eg = (out_m.blank && out_m.col[1]) ? 8'hFF : 8'h00;
    eb = (out_m.blank && out_m.col[0]) ? 8'hFF : 8'h00;
    ok = (vga_hs === out_m.hs) && (vga_vs === out_m.vs) &&
         (vga_blank_n === out_m.blank) && (frame_start === out_m.fs) &&
         (bus.clear_busy === (clr_left_m > 0));
    if (out_m.known)
      ok = ok && (vga_r === er) && (vga_g === eg) && (vga_b === eb);
    checks++;
    if (!ok) begin
      errors++;
      if (fail_prints < 10) begin
        fail_prints++;
        $display("FAIL cycle_model t=%0t pos=(%0d,%0d) got hs=%b vs=%b bl=%b fs=%b busy=%b rgb=%h/%h/%h want hs=%b vs=%b bl=%b fs=%b busy=%b rgb=%h/%h/%h",
                 $time, out_m.h, out_m.v, vga_hs, vga_vs, vga_blank_n, frame_start,
                 bus.clear_busy, vga_r, vga_g, vga_b, out_m.hs, out_m.vs, out_m.blank,
                 out_m.fs, (clr_left_m > 0), er, eg, eb);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end else begin
      $display("check %s: %0h ok", name, act);
    end
  endtask

  task automatic do_plot(int x, int y, logic [2:0] c);
    bus.x = 8'(x); bus.y = 7'(y); bus.colour = c; bus.plot = 1'b1;
    @(negedge clk);
    bus.plot = 1'b0;
    $display("plot (%0d,%0d) colour=%b", x, y, c);
  endtask

  // Wait until the outputs show raster position (h,v)
  task automatic wait_out(int h, int v);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (out_m.h == 16'(h) && out_m.v == 16'(v)) found = 1'b1;
    end
    if (!found) chk("wait_out_timeout", 0, 1);
  endtask

  task automatic pix(string name, int h, int v, logic [23:0] rgb);
    wait_out(h, v);
    chk(name, {8'h00, vga_r, vga_g, vga_b}, {8'h00, rgb});
  endtask

  // Pulse clear and count busy cycles; optionally plot (5,5,100) mid-clear
  task automatic clear_and_count(int plot_at, output int cnt);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    cnt = 0;
    while (bus.clear_busy && cnt < 4 * N) begin
      if (cnt == plot_at) begin
        bus.x = 8'd5; bus.y = 7'd5; bus.colour = 3'b100; bus.plot = 1'b1;
      end else begin
        bus.plot = 1'b0;
      end
      cnt++;
      @(negedge clk);
    end
    bus.plot = 1'b0;
    $display("clear done busy_cycles=%0d", cnt);
  endtask

  task automatic fill_white();
    for (int y = 0; y < V_RES; y++)
      for (int x = 0; x < H_RES; x++) begin
        bus.x = 8'(x); bus.y = 7'(y); bus.colour = 3'b111; bus.plot = 1'b1;
        @(negedge clk);
      end
    bus.plot = 1'b0;
    $display("fill 111 done");
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  int cnt, hs_low, vs_low, bl_hi, fs_cnt, run;
  bit found;

  initial begin
    bus.x = '0; bus.y = '0; bus.colour = '0; bus.plot = 1'b0; bus.clear = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_hs", {31'd0, vga_hs}, 1);
    chk("reset_vs", {31'd0, vga_vs}, 1);
    chk("reset_blank_n", {31'd0, vga_blank_n}, 0);
    chk("reset_busy", {31'd0, bus.clear_busy}, 0);
    rst = 1'b0;

    // Initialise the frame and measure clear duration
    clear_and_count(-1, cnt);
    chk("clear_busy_cycles", cnt, 48);

    // Corner pixels and out-of-range write
    do_plot(0, 0, 3'b101);
    do_plot(7, 5, 3'b010);
    do_plot(8, 2, 3'b111);
    wait_out(0, 0);
    chk("fs_at_origin", {31'd0, frame_start}, 1);
    chk("rgb_origin", {8'h00, vga_r, vga_g, vga_b}, 32'h00FF00FF);
    pix("rgb_origin_block_3_3", 3, 3, 24'hFF00FF);
    pix("oob_addr16", 0, 8, 24'h000000);
    pix("oob_addr24", 0, 12, 24'h000000);
    pix("last_block_green", 28, 20, 24'h00FF00);
    pix("last_block_corner", 31, 23, 24'h00FF00);

    // Sync widths and frame period
    wait_out(47, 1);
    chk("hs_before_656", {31'd0, vga_hs}, 1);
    @(negedge clk);
    run = 0;
    while (!vga_hs && run < 200) begin run++; @(negedge clk); end
    chk("hs_low_run", run, 96);
    wait_out(0, 0);
    hs_low = 0; vs_low = 0; bl_hi = 0; fs_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (!vga_hs) hs_low++;
      if (!vga_vs) vs_low++;
      if (vga_blank_n) bl_hi++;
      if (frame_start) fs_cnt++;
      @(negedge clk);
    end
    chk("frame_period", {31'd0, frame_start}, 1);
    chk("fs_per_frame", fs_cnt, 1);
    chk("hs_low_per_frame", hs_low, 3744);
    chk("vs_low_per_frame", vs_low, 304);
    chk("blank_hi_per_frame", bl_hi, 768);

    // Randomized plots with occasional clears
    for (int i = 0; i < 1500; i++) begin
      bus.plot   = ($urandom % 3) != 0;
      bus.x      = 8'($urandom_range(0, 9));
      bus.y      = 7'($urandom_range(0, 7));
      bus.colour = 3'($urandom);
      bus.clear  = ($urandom % 400) == 0;
      @(negedge clk);
    end
    bus.plot = 1'b0; bus.clear = 1'b0;
    $display("random phase done");
    cnt = 0;
    while (bus.clear_busy && cnt < 4 * N) begin cnt++; @(negedge clk); end

    // Fill white, clear with a blocked plot in the middle
    fill_white();
    clear_and_count(10, cnt);
    chk("clear2_busy_cycles", cnt, 48);
    pix("after_clear_block_1_1", 4, 4, 24'h000000);
    pix("blocked_plot_5_5", 20, 20, 24'h000000);

    // Reset in the middle of a clear
    fill_white();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midclear_rst_busy", {31'd0, bus.clear_busy}, 0);
    chk("midclear_rst_hs", {31'd0, vga_hs}, 1);
    chk("midclear_rst_vs", {31'd0, vga_vs}, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pix("cleared_addr10", 8, 4, 24'h000000);
    pix("cleared_addr19", 12, 8, 24'h000000);
    pix("kept_addr20", 16, 8, 24'hFFFFFF);
    pix("kept_addr30", 24, 12, 24'hFFFFFF);

    // Plot the address the scan is reading on the same cycle
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (pos_m == 16 * HT + 28) found = 1'b1;
    end
    if (!found) chk("hazard_align_timeout", 0, 1);
    do_plot(7, 4, 3'b001);
    pix("hazard_old_colour", 28, 16, 24'hFFFFFF);
    pix("hazard_new_colour", 28, 16, 24'h0000FF);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
